// File: rtl/gf2m_poly_reducer_if.sv
// Valid/ready product-in / remainder-out bundle for the GF(2^m) reducer.
// The reducer takes the slave side; the upstream/downstream pair takes the master side.
interface gf2m_poly_reducer_if #(
  parameter int WIDTH      = 163,
  parameter int PROD_WIDTH = 326
);
  logic                  in_valid;
  logic                  in_ready;
  logic [PROD_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gf2m_poly_reducer.sv
// Sequential reduction of a carry-less product modulo x^WIDTH + POLY,
// folding DIGIT product bits per cycle from the top down.
module gf2m_poly_reducer #(
  parameter int               WIDTH      = 163,
  parameter int               PROD_WIDTH = 326,
  parameter logic [WIDTH-1:0] POLY       = 163'hC9,
  parameter int               DIGIT      = 1
) (
  input  logic                clk,
  input  logic                rst,
  gf2m_poly_reducer_if.slave  bus,
  output logic                busy
);

  localparam int SEL_W = $clog2(PROD_WIDTH);
  localparam int IDX_W = SEL_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [PROD_WIDTH-1:0] r, r_fold;
  logic [IDX_W-1:0]      idx;
  logic                  last_digit;
  logic [WIDTH-1:0]      out_data_q;
  logic                  out_valid_q;

  // Clears each set bit j >= WIDTH by XORing the full field polynomial aligned at j.
  function automatic logic [PROD_WIDTH-1:0] fold_digit(
    input logic [PROD_WIDTH-1:0] v,
    input logic [IDX_W-1:0]      top
  );
    logic [PROD_WIDTH-1:0] f_full;
    logic [PROD_WIDTH-1:0] res;
    logic [SEL_W-1:0]      jj;
    int                    j;
    f_full = {{(PROD_WIDTH-WIDTH-1){1'b0}}, 1'b1, POLY};
    res    = v;
    for (int k = 0; k < DIGIT; k++) begin
      j  = int'(top) - k;
      jj = SEL_W'(j);
      if (j >= WIDTH && j < PROD_WIDTH) begin
        if (res[jj]) res = res ^ (f_full << (j - WIDTH));
      end
    end
    return res;
  endfunction

  assign r_fold     = fold_digit(r, idx);
  assign last_digit = (idx < IDX_W'(WIDTH + DIGIT));

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state == RUN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_digit)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      r           <= '0;
      idx         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            r   <= bus.in_data;
            idx <= IDX_W'(PROD_WIDTH - 1);
          end
        end
        RUN: begin
          r   <= r_fold;
          idx <= idx - IDX_W'(DIGIT);
          // Result is captured from the post-fold value of the final digit.
          if (last_digit) begin
            out_data_q  <= r_fold[WIDTH-1:0];
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
